// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencing controller: load-use stall, branch/jump flush,
// debug run/step/pause control and post-HALT drain for a 5-stage MIPS pipeline.
module pipeline_hazard_ctrl #(
  parameter int REG_ADDR_W   = 5,
  parameter int DRAIN_CYCLES = 4,
  parameter int CNT_W        = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_dbg_run,
  input  logic                  i_dbg_step,
  input  logic                  i_dbg_pause,
  input  logic [REG_ADDR_W-1:0] i_id_rs_addr,
  input  logic [REG_ADDR_W-1:0] i_id_rt_addr,
  input  logic                  i_id_uses_rt,
  input  logic                  i_id_jump,
  input  logic                  i_id_halt,
  input  logic [REG_ADDR_W-1:0] i_ex_rt_addr,
  input  logic                  i_ex_MemRead,
  input  logic                  i_ex_branch_taken,
  output logic                  o_pipe_en,
  output logic                  o_pc_en,
  output logic                  o_if_id_en,
  output logic                  o_if_id_flush,
  output logic                  o_id_ex_bubble,
  output logic [1:0]            o_state,
  output logic [CNT_W-1:0]      o_cycle_cnt,
  output logic                  o_halted
);

  localparam int DW = (DRAIN_CYCLES > 2) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } state_t;

  state_t          state;
  logic [DW-1:0]   drain_cnt;
  logic            exec_cycle;
  logic            drain_cycle;
  logic            active;
  logic            load_use;
  logic            live_halt;

  // rst gates the active terms so every enable drops while reset is held
  assign exec_cycle  = !rst && ((state == RUN) || ((state == IDLE) && i_dbg_step));
  assign drain_cycle = !rst && (state == DRAIN);
  assign active      = exec_cycle || drain_cycle;
  assign live_halt   = i_id_halt && !i_ex_branch_taken;
  assign load_use    = i_ex_MemRead && (i_ex_rt_addr != '0) &&
                       ((i_ex_rt_addr == i_id_rs_addr) ||
                        (i_id_uses_rt && (i_ex_rt_addr == i_id_rt_addr)));

  // Latch and PC control for the current cycle
  always_comb begin
    o_pipe_en      = 1'b0;
    o_pc_en        = 1'b0;
    o_if_id_en     = 1'b0;
    o_if_id_flush  = 1'b0;
    o_id_ex_bubble = 1'b0;
    if (drain_cycle) begin
      o_pipe_en      = 1'b1;
      o_if_id_en     = 1'b1;
      o_if_id_flush  = 1'b1;
      o_id_ex_bubble = 1'b1;
    end else if (exec_cycle) begin
      o_pipe_en = 1'b1;
      if (i_ex_branch_taken) begin
        o_pc_en        = 1'b1;
        o_if_id_en     = 1'b1;
        o_if_id_flush  = 1'b1;
        o_id_ex_bubble = 1'b1;
      end else if (load_use) begin
        o_id_ex_bubble = 1'b1;
      end else if (i_id_jump) begin
        o_pc_en       = 1'b1;
        o_if_id_en    = 1'b1;
        o_if_id_flush = 1'b1;
      end else begin
        o_pc_en    = 1'b1;
        o_if_id_en = 1'b1;
      end
      // HALT must not fetch past itself; the flush keeps IF/ID empty behind it
      if (live_halt) begin
        o_pc_en       = 1'b0;
        o_if_id_flush = 1'b1;
      end else begin
        o_pc_en       = o_pc_en;
      end
    end else begin
      o_pipe_en = 1'b0;
    end
  end

  // Debug/halt sequencing state machine and drain counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      drain_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_dbg_step && live_halt) begin
            state     <= DRAIN;
            drain_cnt <= DW'(DRAIN_CYCLES - 1);
          end else if (i_dbg_run) begin
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          if (i_dbg_pause) begin
            state <= IDLE;
          end else if (live_halt) begin
            state     <= DRAIN;
            drain_cnt <= DW'(DRAIN_CYCLES - 1);
          end else begin
            state <= RUN;
          end
        end
        DRAIN: begin
          if (drain_cnt == '0) begin
            state <= HALTED;
          end else begin
            drain_cnt <= drain_cnt - DW'(1);
          end
        end
        HALTED:  state <= HALTED;
        default: state <= IDLE;
      endcase
    end
  end

  // Executed-cycle counter, wraps naturally
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_cycle_cnt <= '0;
    end else if (active) begin
      o_cycle_cnt <= o_cycle_cnt + CNT_W'(1);
    end else begin
      o_cycle_cnt <= o_cycle_cnt;
    end
  end

  assign o_state  = state;
  assign o_halted = (state == HALTED);

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed scoreboard bench for pipeline_hazard_ctrl.
module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        dbg_run, dbg_step, dbg_pause;
  logic [4:0]  id_rs, id_rt, ex_rt;
  logic        id_uses_rt, id_jump, id_halt, ex_memread, ex_branch;
  logic        pipe_en, pc_en, if_id_en, if_id_flush, id_ex_bubble, halted;
  logic [1:0]  state;
  logic [31:0] cycle_cnt;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] exp_cnt  = 32'd0;
  logic [7:0]  exp_q[$];
  string       tag_q[$];

  pipeline_hazard_ctrl #(.REG_ADDR_W(5), .DRAIN_CYCLES(4), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .i_dbg_run(dbg_run), .i_dbg_step(dbg_step), .i_dbg_pause(dbg_pause),
    .i_id_rs_addr(id_rs), .i_id_rt_addr(id_rt), .i_id_uses_rt(id_uses_rt),
    .i_id_jump(id_jump), .i_id_halt(id_halt),
    .i_ex_rt_addr(ex_rt), .i_ex_MemRead(ex_memread), .i_ex_branch_taken(ex_branch),
    .o_pipe_en(pipe_en), .o_pc_en(pc_en), .o_if_id_en(if_id_en),
    .o_if_id_flush(if_id_flush), .o_id_ex_bubble(id_ex_bubble),
    .o_state(state), .o_cycle_cnt(cycle_cnt), .o_halted(halted)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mk(input logic pe, input logic pc, input logic ie,
                                    input logic fl, input logic bu, input logic [1:0] st);
    return {pe, pc, ie, fl, bu, st, (st == 2'd3)};
  endfunction

  function automatic logic [7:0] obs_vec();
    return {pipe_en, pc_en, if_id_en, if_id_flush, id_ex_bubble, state, halted};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clr_in();
    dbg_run = 1'b0; dbg_step = 1'b0; dbg_pause = 1'b0;
    id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0;
    id_uses_rt = 1'b0; id_jump = 1'b0; id_halt = 1'b0;
    ex_memread = 1'b0; ex_branch = 1'b0;
  endtask

  // one clock: push expectation, compare mid-cycle, advance past the edge
  task automatic cyc(input string tag, input logic [7:0] e);
    logic [7:0] x;
    string      t;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(negedge clk);
    x = exp_q.pop_front();
    t = tag_q.pop_front();
    chk(t, {24'd0, obs_vec()}, {24'd0, x});
    chk({t, "_cnt"}, cycle_cnt, exp_cnt);
    @(posedge clk);
    #1;
    if (x[7]) exp_cnt = exp_cnt + 32'd1;
  endtask

  initial begin
    clr_in();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_vec", {24'd0, obs_vec()}, {24'd0, mk(0, 0, 0, 0, 0, 2'd0)});
    chk("reset_cnt", cycle_cnt, 32'd0);
    rst = 1'b0;

    // single steps from IDLE
    for (int i = 0; i < 3; i++) begin
      dbg_step = 1'b1;
      cyc("step", mk(1, 1, 1, 0, 0, 2'd0));
      dbg_step = 1'b0;
      cyc("step_gap", mk(0, 0, 0, 0, 0, 2'd0));
    end
    chk("step_total", cycle_cnt, 32'd3);

    dbg_run = 1'b1;
    cyc("idle_to_run", mk(0, 0, 0, 0, 0, 2'd0));
    cyc("run_plain", mk(1, 1, 1, 0, 0, 2'd1));

    // load-use via rs, then rt=0 exception, then via rt, then non-load
    ex_memread = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
    cyc("lu_rs", mk(1, 0, 0, 0, 1, 2'd1));
    ex_rt = 5'd0; id_rs = 5'd0;
    cyc("lu_r0", mk(1, 1, 1, 0, 0, 2'd1));
    ex_rt = 5'd9; id_rs = 5'd3; id_rt = 5'd9; id_uses_rt = 1'b1;
    cyc("lu_rt", mk(1, 0, 0, 0, 1, 2'd1));
    id_uses_rt = 1'b0;
    cyc("lu_rt_unused", mk(1, 1, 1, 0, 0, 2'd1));
    id_uses_rt = 1'b1; ex_memread = 1'b0;
    cyc("no_load", mk(1, 1, 1, 0, 0, 2'd1));

    // branch overrides load-use
    ex_memread = 1'b1; ex_rt = 5'd5; id_rs = 5'd5; ex_branch = 1'b1;
    cyc("br_over_lu", mk(1, 1, 1, 1, 1, 2'd1));
    clr_in(); dbg_run = 1'b1; id_jump = 1'b1;
    cyc("jump", mk(1, 1, 1, 1, 0, 2'd1));

    // halt squashed by branch stays in RUN
    clr_in(); dbg_run = 1'b1; id_halt = 1'b1; ex_branch = 1'b1;
    cyc("halt_br", mk(1, 1, 1, 1, 1, 2'd1));
    clr_in(); dbg_run = 1'b1;
    cyc("halt_br_next", mk(1, 1, 1, 0, 0, 2'd1));

    // pause beats live halt
    clr_in(); dbg_pause = 1'b1; id_halt = 1'b1;
    cyc("pause_halt", mk(1, 0, 1, 1, 0, 2'd1));
    clr_in();
    cyc("paused", mk(0, 0, 0, 0, 0, 2'd0));

    // fill to 57 executed cycles, then reset asynchronously mid-cycle
    dbg_run = 1'b1;
    cyc("rerun", mk(0, 0, 0, 0, 0, 2'd0));
    while (exp_cnt < 32'd57) cyc("fill", mk(1, 1, 1, 0, 0, 2'd1));
    chk("cnt57", cycle_cnt, 32'd57);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_vec", {24'd0, obs_vec()}, {24'd0, mk(0, 0, 0, 0, 0, 2'd0)});
    chk("async_rst_cnt", cycle_cnt, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_cnt = 32'd0;

    // halt -> 4 drain cycles -> HALTED; debug inputs ignored throughout
    cyc("rerun2", mk(0, 0, 0, 0, 0, 2'd0));
    id_halt = 1'b1;
    cyc("halt", mk(1, 0, 1, 1, 0, 2'd1));
    clr_in(); dbg_pause = 1'b1;
    for (int i = 0; i < 4; i++) cyc("drain", mk(1, 0, 1, 1, 1, 2'd2));
    clr_in(); dbg_run = 1'b1;
    cyc("halted", mk(0, 0, 0, 0, 0, 2'd3));
    dbg_step = 1'b1;
    cyc("halted_step", mk(0, 0, 0, 0, 0, 2'd3));
    dbg_step = 1'b0;
    cyc("halted_hold", mk(0, 0, 0, 0, 0, 2'd3));
    chk("halted_cnt", cycle_cnt, 32'd5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Sequencing controller for the 5-stage MIPS pipeline latches (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC.
- Detects load-use hazards and stalls the front end while inserting a bubble into ID/EX.
- Flushes on taken branches and jumps.
- Implements the debug-unit run/step/pause control and drains the pipeline after a HALT instruction.
- Sits beside the ID stage and drives the enable, flush and bubble inputs of the latches and PC.

Parameters:
REG_ADDR_W, 5, register-address width
DRAIN_CYCLES, 4, cycles needed to retire instructions behind HALT (ID..WB)
CNT_W, 32, width of the executed-cycle counter

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
i_dbg_run  in  1  level; request continuous execution
i_dbg_step  in  1  one-cycle pulse; execute exactly one clock
i_dbg_pause  in  1  level; stop continuous execution
i_id_rs_addr  in  REG_ADDR_W  rs of instruction in ID
i_id_rt_addr  in  REG_ADDR_W  rt of instruction in ID
i_id_uses_rt  in  1  instruction in ID reads rt as a source
i_id_jump  in  1  instruction in ID is J/JAL/JR/JALR
i_id_halt  in  1  instruction in ID is HALT
i_ex_rt_addr  in  REG_ADDR_W  rt address at ID/EX output
i_ex_MemRead  in  1  MemRead at ID/EX output
i_ex_branch_taken  in  1  branch in EX resolved taken
o_pipe_en  out  1  global enable for all pipeline latches and PC
o_pc_en  out  1  PC write enable
o_if_id_en  out  1  IF/ID write enable
o_if_id_flush  out  1  IF/ID loads a NOP
o_id_ex_bubble  out  1  ID/EX loads zeroed control signals
o_state  out  2  0=IDLE 1=RUN 2=DRAIN 3=HALTED
o_cycle_cnt  out  CNT_W  count of enabled clocks since reset
o_halted  out  1  state==HALTED

Behaviour:
- Reset (async, immediate, including mid-operation):
  - state=IDLE, drain counter=0, o_cycle_cnt=0.
  - All combinational outputs take their IDLE values: every enable/flush/bubble output is 0.
- FSM, registered on posedge clk:
  - IDLE->RUN when i_dbg_run.
  - IDLE stays IDLE on i_dbg_step, but that cycle is a step cycle. If run and step are both asserted, run wins.
  - RUN->IDLE when i_dbg_pause; pause has priority over halt detection in the same cycle.
  - RUN or step cycle -> DRAIN when "live halt": i_id_halt && !i_ex_branch_taken. The drain counter loads DRAIN_CYCLES-1.
  - DRAIN: the counter decrements each clock; at 0 the next state is HALTED. i_dbg_* are ignored in DRAIN.
  - HALTED is terminal until rst.
- Active cycle = RUN, or IDLE with i_dbg_step, or DRAIN. o_pipe_en=1 only in active cycles; otherwise everything holds, with pc_en, if_id_en, flush and bubble all 0.
- In an active non-DRAIN cycle, combinational, in priority order:
  1. Branch taken: pc_en=1, if_id_en=1, if_id_flush=1, id_ex_bubble=1. This also suppresses any load-use stall.
  2. Load-use: i_ex_MemRead && i_ex_rt_addr!=0 && (i_ex_rt_addr==i_id_rs_addr || (i_id_uses_rt && i_ex_rt_addr==i_id_rt_addr)). Result: pc_en=0, if_id_en=0, if_id_flush=0, id_ex_bubble=1. This lasts exactly one cycle, because the bubble clears i_ex_MemRead.
  3. Jump in ID: pc_en=1, if_id_en=1, if_id_flush=1, id_ex_bubble=0.
  4. Otherwise: pc_en=1, if_id_en=1, no flush, no bubble.
  - A live halt additionally forces pc_en=0 and if_id_flush=1 in its cycle.
- DRAIN: pc_en=0, if_id_en=1, if_id_flush=1, id_ex_bubble=1.
- o_cycle_cnt increments by 1 on every active cycle and wraps modulo 2^CNT_W.

Test Plan:
1. Reset pulse mid-RUN (cnt=57) -> state=IDLE, o_cycle_cnt=0 and all enables 0 asynchronously, before the next clk edge.
2. IDLE, i_dbg_step pulsed on 3 separate cycles -> o_pipe_en high for exactly 3 clocks, o_cycle_cnt=3, state stays IDLE.
3. RUN, ex_MemRead=1, ex_rt=5, id_rs=5 -> for one cycle pc_en=0, if_id_en=0, id_ex_bubble=1; ex_rt=0 with the same inputs gives no stall.
4. RUN, load-use and i_ex_branch_taken asserted together -> pc_en=1, if_id_flush=1, id_ex_bubble=1, no stall.
5. RUN, i_id_halt=1 -> DRAIN for 4 clocks (pc_en=0), then HALTED, o_halted=1, o_cycle_cnt frozen. i_dbg_run afterwards has no effect.
6. RUN, i_id_halt=1 with i_ex_branch_taken=1 -> stays RUN, branch flush only. Pause asserted together with a live halt -> IDLE.
